// File: rtl/escalonador_memoria_obstaculos.sv
// Arbiter for the single-port obstacle memory: external writes win, reads are
// granted round-robin, and each read's data returns on its requester's lane.
module escalonador_memoria_obstaculos #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 1,
    parameter int NUM_PORTS  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_in,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  addr_in,
    output logic [NUM_PORTS-1:0]             grant_out,
    output logic [DATA_WIDTH*NUM_PORTS-1:0]  data_out,
    output logic [NUM_PORTS-1:0]             data_valid_out,
    input  logic                             ext_wr_en_in,
    input  logic [ADDR_WIDTH-1:0]            ext_wr_addr_in,
    input  logic [DATA_WIDTH-1:0]            ext_wr_data_in,
    output logic                             mem_rd_en_out,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr_out,
    input  logic [DATA_WIDTH-1:0]            mem_rd_data_in,
    output logic                             mem_wr_en_out,
    output logic [ADDR_WIDTH-1:0]            mem_wr_addr_out,
    output logic [DATA_WIDTH-1:0]            mem_wr_data_out,
    output logic                             busy_out
);

    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]            grant_q;
    logic [PW-1:0]                   rr_ptr_q;
    logic                            mem_rd_en_q;
    logic [ADDR_WIDTH-1:0]           mem_rd_addr_q;
    logic [PW-1:0]                   rd_tag_q;
    logic                            ret_vld_q;
    logic [PW-1:0]                   ret_tag_q;
    logic                            mem_wr_en_q;
    logic [ADDR_WIDTH-1:0]           mem_wr_addr_q;
    logic [DATA_WIDTH-1:0]           mem_wr_data_q;
    logic [DATA_WIDTH*NUM_PORTS-1:0] data_q;
    logic [NUM_PORTS-1:0]            data_valid_q;
    logic                            busy_q;

    logic [NUM_PORTS-1:0]            eligible;
    logic [PW-1:0]                   cand;
    logic [PW-1:0]                   win_idx;
    logic                            win_found;
    logic                            rd_issue;

    // Handshake: a requester holds req_in (and a stable addr_in lane) until it
    // sees its one-cycle grant_out pulse, then drops req on the following edge.
    // The port being granted this cycle is masked so it cannot win twice.
    always_comb begin
        eligible  = req_in & ~grant_q;
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = rr_ptr_q + PW'(i);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        rd_issue = !ext_wr_en_in && win_found;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            rd_tag_q      <= '0;
            ret_vld_q     <= 1'b0;
            ret_tag_q     <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            data_q        <= '0;
            data_valid_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            mem_wr_en_q <= ext_wr_en_in;
            if (ext_wr_en_in) begin
                mem_wr_addr_q <= ext_wr_addr_in;
                mem_wr_data_q <= ext_wr_data_in;
            end

            mem_rd_en_q <= rd_issue;
            grant_q     <= rd_issue ? (NUM_PORTS'(1) << win_idx) : '0;
            if (rd_issue) begin
                mem_rd_addr_q <= addr_in[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                rd_tag_q      <= win_idx;
                rr_ptr_q      <= win_idx + PW'(1);
            end

            // Tag follows the read through the memory's one-cycle latency.
            ret_vld_q    <= mem_rd_en_q;
            ret_tag_q    <= rd_tag_q;
            data_valid_q <= '0;
            if (ret_vld_q) begin
                data_q[ret_tag_q*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data_in;
                data_valid_q[ret_tag_q]                    <= 1'b1;
            end

            busy_q <= (|req_in) | mem_rd_en_q | ret_vld_q;
        end
    end

    assign grant_out       = grant_q;
    assign data_out        = data_q;
    assign data_valid_out  = data_valid_q;
    assign mem_rd_en_out   = mem_rd_en_q;
    assign mem_rd_addr_out = mem_rd_addr_q;
    assign mem_wr_en_out   = mem_wr_en_q;
    assign mem_wr_addr_out = mem_wr_addr_q;
    assign mem_wr_data_out = mem_wr_data_q;
    assign busy_out        = busy_q;

endmodule
